// File: rtl/tick_generator_bank.sv
// Bank of independent, runtime-programmable clock-enable generators sharing one clock.
// Each channel emits a 1-cycle Tick every DIV cycles and a 50%-duty Square of period 2*DIV.
module tick_generator_bank #(
    parameter int unsigned                    NUM_CH    = 3,
    parameter int unsigned                    DIV_W     = 28,
    parameter logic [NUM_CH*DIV_W-1:0]        RESET_DIV = {NUM_CH{DIV_W'(1000)}},
    parameter logic [NUM_CH-1:0]              RESET_EN  = {NUM_CH{1'b1}}
) (
    input  logic              MasterClock,
    input  logic              ResetN,
    input  logic              CfgWe,
    input  logic [3:0]        CfgCh,
    input  logic [DIV_W-1:0]  CfgDiv,
    input  logic              CfgEn,
    input  logic              CfgImm,
    input  logic              Sync,
    output logic [NUM_CH-1:0] Tick,
    output logic [NUM_CH-1:0] Square,
    output logic [NUM_CH-1:0] Pending
);

    localparam logic [4:0] NUM_CH_W = 5'(NUM_CH);

    logic cfg_hit;
    assign cfg_hit = CfgWe && ({1'b0, CfgCh} < NUM_CH_W);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        localparam logic [3:0] CH = 4'(g);

        logic [DIV_W-1:0] cnt_q, cnt_d;
        logic [DIV_W-1:0] div_q, div_d;
        logic [DIV_W-1:0] pdiv_q, pdiv_d;
        logic             pend_q, pend_d;
        logic             en_q, en_d;
        logic             tick_q, tick_d;
        logic             sq_q, sq_d;
        logic             wr, active, tc;

        always_comb begin
            wr     = cfg_hit && (CfgCh == CH);
            active = en_q && (div_q != '0);
            // Sync suppresses TC so that div and pend stay untouched in that cycle.
            tc     = active && (cnt_q == div_q - DIV_W'(1)) && !Sync;

            cnt_d  = cnt_q;
            div_d  = div_q;
            pdiv_d = pdiv_q;
            pend_d = pend_q;
            en_d   = en_q;
            tick_d = 1'b0;
            sq_d   = sq_q;

            if (active) begin
                if (tc) begin
                    cnt_d  = '0;
                    tick_d = 1'b1;
                    sq_d   = ~sq_q;
                    if (pend_q) begin
                        div_d  = pdiv_q;
                        pend_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end else begin
                cnt_d = '0;
                sq_d  = 1'b0;
            end

            if (wr) begin
                en_d = CfgEn;
                // Disabling write or idle channel stores the divisor directly and restarts.
                if (CfgImm || !active || !CfgEn) begin
                    div_d  = CfgDiv;
                    cnt_d  = '0;
                    sq_d   = 1'b0;
                    pend_d = 1'b0;
                    tick_d = 1'b0;
                end else if (tc) begin
                    div_d  = CfgDiv;
                    pend_d = 1'b0;
                end else begin
                    pdiv_d = CfgDiv;
                    pend_d = 1'b1;
                end
            end

            if (Sync) begin
                cnt_d  = '0;
                sq_d   = 1'b0;
                tick_d = 1'b0;
            end
        end

        always_ff @(posedge MasterClock) begin
            if (!ResetN) begin
                cnt_q  <= '0;
                div_q  <= RESET_DIV[g*DIV_W +: DIV_W];
                pdiv_q <= '0;
                pend_q <= 1'b0;
                en_q   <= RESET_EN[g];
                tick_q <= 1'b0;
                sq_q   <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                div_q  <= div_d;
                pdiv_q <= pdiv_d;
                pend_q <= pend_d;
                en_q   <= en_d;
                tick_q <= tick_d;
                sq_q   <= sq_d;
            end
        end

        assign Tick[g]    = tick_q;
        assign Square[g]  = sq_q;
        assign Pending[g] = pend_q;
    end

endmodule

// File: tb/tb_tick_generator_bank.sv
// Directed self-checking bench for tick_generator_bank (3 channels, reset divisors 4/10/100).
module tb_tick_generator_bank;

    logic        MasterClock = 1'b0;
    logic        ResetN      = 1'b0;
    logic        CfgWe       = 1'b0;
    logic [3:0]  CfgCh       = '0;
    logic [15:0] CfgDiv      = '0;
    logic        CfgEn       = 1'b0;
    logic        CfgImm      = 1'b0;
    logic        Sync        = 1'b0;
    logic [2:0]  Tick;
    logic [2:0]  Square;
    logic [2:0]  Pending;

    int n_checks = 0;
    int n_errors = 0;

    tick_generator_bank #(
        .NUM_CH    (3),
        .DIV_W     (16),
        .RESET_DIV ({16'd100, 16'd10, 16'd4}),
        .RESET_EN  (3'b111)
    ) dut (
        .MasterClock (MasterClock),
        .ResetN      (ResetN),
        .CfgWe       (CfgWe),
        .CfgCh       (CfgCh),
        .CfgDiv      (CfgDiv),
        .CfgEn       (CfgEn),
        .CfgImm      (CfgImm),
        .Sync        (Sync),
        .Tick        (Tick),
        .Square      (Square),
        .Pending     (Pending)
    );

    always #5 MasterClock = ~MasterClock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge MasterClock);
        #1;
    endtask

    task automatic cfg(input logic [3:0] ch, input logic [15:0] dv, input logic en, input logic imm);
        CfgWe  = 1'b1;
        CfgCh  = ch;
        CfgDiv = dv;
        CfgEn  = en;
        CfgImm = imm;
    endtask

    task automatic clr();
        CfgWe = 1'b0;
        Sync  = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) cyc();
        chk("rst_tick", 32'(Tick), 32'd0);
        chk("rst_sq", 32'(Square), 32'd0);
        chk("rst_pend", 32'(Pending), 32'd0);

        // 1: ch0 div 4 ticks at 4, 8, 12; ch1 div 10 ticks at 10
        ResetN = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            chk("t1_tick0", 32'(Tick[0]), 32'(k % 4 == 0));
            chk("t1_sq0", 32'(Square[0]), 32'((k / 4) % 2 == 1));
            chk("t1_tick1", 32'(Tick[1]), 32'(k == 10));
            chk("t1_tick2", 32'(Tick[2]), 32'd0);
        end

        // 2: ch1 deferred write div 3 at cnt 5
        Sync = 1'b1;
        cyc();
        clr();
        chk("t2_sync_sq", 32'(Square), 32'd0);
        for (int j = 1; j <= 17; j++) begin
            if (j == 6) cfg(4'd1, 16'd3, 1'b1, 1'b0);
            cyc();
            clr();
            chk("t2_tick1", 32'(Tick[1]), 32'(j == 10 || j == 13 || j == 16));
            chk("t2_pend1", 32'(Pending[1]), 32'(j >= 6 && j < 10));
        end

        // 3: ch2 div 100, immediate write div 2 at cnt 70
        Sync = 1'b1;
        cyc();
        clr();
        for (int j = 1; j <= 170; j++) begin
            cyc();
            if (j == 100) chk("t3_tick2_100", 32'(Tick[2]), 32'd1);
        end
        chk("t3_sq2_pre", 32'(Square[2]), 32'd1);
        cfg(4'd2, 16'd2, 1'b1, 1'b1);
        cyc();
        clr();
        chk("t3_tick2_w", 32'(Tick[2]), 32'd0);
        chk("t3_sq2_w", 32'(Square[2]), 32'd0);
        for (int m = 1; m <= 4; m++) begin
            cyc();
            chk("t3_tick2", 32'(Tick[2]), 32'(m == 2 || m == 4));
            chk("t3_sq2", 32'(Square[2]), 32'(m == 2 || m == 3));
        end

        // 4: disable ch0, then re-enable with div 5
        cfg(4'd0, 16'd4, 1'b0, 1'b0);
        cyc();
        clr();
        for (int j = 0; j < 8; j++) begin
            chk("t4_off_tick0", 32'(Tick[0]), 32'd0);
            chk("t4_off_sq0", 32'(Square[0]), 32'd0);
            cyc();
        end
        cfg(4'd0, 16'd5, 1'b1, 1'b0);
        cyc();
        clr();
        chk("t4_w_tick0", 32'(Tick[0]), 32'd0);
        for (int j = 1; j <= 10; j++) begin
            cyc();
            chk("t4_tick0", 32'(Tick[0]), 32'(j % 5 == 0));
            chk("t4_sq0", 32'(Square[0]), 32'(j >= 5 && j < 10));
        end

        // 5/6: Sync aligns equal divisors; out-of-range channel writes ignored
        cfg(4'd1, 16'd5, 1'b1, 1'b1);
        cyc();
        clr();
        repeat (2) cyc();
        Sync = 1'b1;
        cyc();
        clr();
        chk("t5_sync_sq", 32'(Square), 32'd0);
        chk("t5_sync_tick", 32'(Tick), 32'd0);
        for (int j = 1; j <= 10; j++) begin
            if (j == 3) cfg(4'd7, 16'd1, 1'b0, 1'b1);
            if (j == 7) cfg(4'd4, 16'd1, 1'b0, 1'b1);
            cyc();
            clr();
            chk("t5_tick0", 32'(Tick[0]), 32'(j % 5 == 0));
            chk("t5_tick1", 32'(Tick[1]), 32'(j % 5 == 0));
            chk("t5_tick2", 32'(Tick[2]), 32'(j % 2 == 0));
            chk("t5_sq0", 32'(Square[0]), 32'(j >= 5 && j < 10));
            chk("t5_sq2", 32'(Square[2]), 32'((j / 2) % 2 == 1));
            chk("t5_pend", 32'(Pending), 32'd0);
        end

        // div 0 never ticks
        cfg(4'd2, 16'd0, 1'b1, 1'b1);
        cyc();
        clr();
        for (int j = 0; j < 6; j++) begin
            cyc();
            chk("t6_div0_tick2", 32'(Tick[2]), 32'd0);
            chk("t6_div0_sq2", 32'(Square[2]), 32'd0);
        end

        // reset mid-period with a pending divisor
        cfg(4'd1, 16'd7, 1'b1, 1'b0);
        cyc();
        clr();
        chk("t6_pend1", 32'(Pending), 32'b010);
        chk("t6_sq_pre", 32'(Square), 32'b011);
        ResetN = 1'b0;
        cyc();
        chk("t6_rst_tick", 32'(Tick), 32'd0);
        chk("t6_rst_sq", 32'(Square), 32'd0);
        chk("t6_rst_pend", 32'(Pending), 32'd0);

        // after reset: ch2 div 1, ch1 deferred write coinciding with its TC
        ResetN = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            if (k == 1) cfg(4'd2, 16'd1, 1'b1, 1'b1);
            if (k == 10) cfg(4'd1, 16'd3, 1'b1, 1'b0);
            cyc();
            clr();
            chk("t7_tick0", 32'(Tick[0]), 32'(k % 4 == 0));
            chk("t7_tick1", 32'(Tick[1]), 32'(k == 10 || k == 13 || k == 16));
            chk("t7_pend1", 32'(Pending[1]), 32'd0);
            chk("t7_tick2", 32'(Tick[2]), 32'(k >= 2));
            chk("t7_sq2", 32'(Square[2]), 32'(k >= 2 && k % 2 == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
